// File: rtl/pred_nbr_buf.sv
// ---------------------------------------------------------------------------
// pred_nbr_buf
//
// Neighbour-pixel store for the intra predictors. Every reconstructed block
// leaves behind two edges:
//   - its bottom row, kept in a per-column line buffer (one entry per block
//     column). A block later predicted below it reads this as its top edge.
//   - its right column, kept in a single left register. The next block to
//     its right reads this as its left edge.
// On request the top edge (line buffer[rd_x]) and the left edge are returned
// as packed pixel vectors.
//
// Optional feature macro: NBR_DEFAULT_EN
//   When defined, a read substitutes boundary defaults for neighbours that
//   lie outside the picture:
//     top  = all 2^(BIT_WIDTH-1)-1 when rd_y == 0
//     left = all 2^(BIT_WIDTH-1)+1 when rd_x == 0
//   When undefined, stored values are returned unchanged and rd_y is unused.
//
// Ports
//   clk       clock, all logic on the rising edge
//   rst       asynchronous, active-high reset
//   wr_start  1-cycle pulse: recon holds a valid reconstructed block
//   wr_x      block column of the written block
//   recon     reconstructed block, row-major, pixel (r,c) at
//             [BIT_WIDTH*(r*BLOCK_SIZE+c) +: BIT_WIDTH]
//   wr_done   1-cycle pulse, BLOCK_SIZE+1 clocks after wr_start was sampled
//   rd_start  1-cycle pulse: neighbour request
//   rd_x      block column of the block being predicted
//   rd_y      block row of the block being predicted
//   top       top edge, pixel i at [BIT_WIDTH*i +: BIT_WIDTH]
//   left      left edge, pixel i = row i of the left neighbour
//   rd_valid  1-cycle pulse: top/left carry the requested edges
//   busy      high whenever the controller is not idle
// ---------------------------------------------------------------------------
module pred_nbr_buf #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 16,
  parameter int BLOCK_NUM  = 10,
  parameter int MAX_MB_W   = 64
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       wr_start,
  input  logic [BLOCK_NUM-1:0]                       wr_x,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] recon,
  output logic                                       wr_done,
  input  logic                                       rd_start,
  input  logic [BLOCK_NUM-1:0]                       rd_x,
  input  logic [BLOCK_NUM-1:0]                       rd_y,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            top,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            left,
  output logic                                       rd_valid,
  output logic                                       busy
);

  localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE;
  localparam int CNT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int ADDR_W = (MAX_MB_W > 1) ? $clog2(MAX_MB_W) : 1;

  // Column limit widened by one bit so the comparison stays exact even when
  // MAX_MB_W equals 2^BLOCK_NUM.
  localparam logic [BLOCK_NUM:0] X_LIMIT  = (BLOCK_NUM + 1)'(MAX_MB_W);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BLOCK_SIZE - 1);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    WR_COL  = 5'b00010,
    WR_DONE = 5'b00100,
    RD      = 5'b01000,
    RD_OUT  = 5'b10000
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------
  // Edge extraction. Only the bottom row and the right column of a block
  // are ever needed, so those are latched instead of the whole block.
  // ---------------------------------------------------------------------
  logic [EDGE_W-1:0] recon_row;
  logic [EDGE_W-1:0] recon_col;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_edge
      assign recon_row[BIT_WIDTH*gi +: BIT_WIDTH] =
        recon[BIT_WIDTH*((BLOCK_SIZE-1)*BLOCK_SIZE + gi) +: BIT_WIDTH];
      assign recon_col[BIT_WIDTH*gi +: BIT_WIDTH] =
        recon[BIT_WIDTH*(gi*BLOCK_SIZE + BLOCK_SIZE - 1) +: BIT_WIDTH];
    end
  endgenerate

  // Interior pixels of the block are intentionally dropped.
  logic unused_recon;
  assign unused_recon = ^recon;

  // ---------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------
  logic [BLOCK_NUM-1:0] wr_x_reg;
  logic [EDGE_W-1:0]    row_reg;
  logic [EDGE_W-1:0]    col_reg;
  logic [EDGE_W-1:0]    left_reg;
  logic [CNT_W-1:0]     count;

  // Active read coordinates, stable throughout RD and RD_OUT.
  logic [BLOCK_NUM-1:0] rd_x_reg;
  logic [BLOCK_NUM-1:0] rd_y_reg;

  // Single-entry pending read; a newer request overwrites the coordinates.
  logic                 pend;
  logic [BLOCK_NUM-1:0] pend_x;
  logic [BLOCK_NUM-1:0] pend_y;

  logic [EDGE_W-1:0]    ram_q;

  logic wr_in_range;
  logic rd_in_range;
  logic ram_we;

  assign wr_in_range = ({1'b0, wr_x_reg} < X_LIMIT);
  assign rd_in_range = ({1'b0, rd_x_reg} < X_LIMIT);

  // The bottom row goes into the line buffer once, on the first WR_COL cycle.
  // Out-of-range columns are dropped so they cannot alias onto a real entry.
  assign ram_we = (state == WR_COL) && (count == '0) && wr_in_range;

`ifdef NBR_DEFAULT_EN
  localparam logic [BIT_WIDTH-1:0] DEF_TOP  = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic [BIT_WIDTH-1:0] DEF_LEFT = BIT_WIDTH'((1 << (BIT_WIDTH - 1)) + 1);
`else
  // Picture row only matters when boundary defaults are substituted.
  logic unused_rd_y;
  assign unused_rd_y = ^rd_y_reg;
`endif

  // ---------------------------------------------------------------------
  // Main FSM. All outputs are registered here.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      top      <= '0;
      left     <= '0;
      left_reg <= '0;
      count    <= '0;
      wr_x_reg <= '0;
      row_reg  <= '0;
      col_reg  <= '0;
      rd_x_reg <= '0;
      rd_y_reg <= '0;
      pend     <= 1'b0;
      pend_x   <= '0;
      pend_y   <= '0;
    end else begin
      wr_done  <= 1'b0;
      rd_valid <= 1'b0;

      // Requests arriving mid-operation are parked. IDLE and WR_DONE can
      // launch a read directly, so they handle rd_start themselves.
      if (rd_start && (state == WR_COL || state == RD || state == RD_OUT)) begin
        pend   <= 1'b1;
        pend_x <= rd_x;
        pend_y <= rd_y;
      end

      case (state)
        IDLE: begin
          if (wr_start) begin
            wr_x_reg <= wr_x;
            row_reg  <= recon_row;
            col_reg  <= recon_col;
            count    <= '0;
            state    <= WR_COL;
            busy     <= 1'b1;
            // Write wins a tie; the read waits so it sees the new edges.
            if (rd_start) begin
              pend   <= 1'b1;
              pend_x <= rd_x;
              pend_y <= rd_y;
            end
          end else if (rd_start || pend) begin
            rd_x_reg <= rd_start ? rd_x : pend_x;
            rd_y_reg <= rd_start ? rd_y : pend_y;
            pend     <= 1'b0;
            state    <= RD;
            busy     <= 1'b1;
          end
        end

        WR_COL: begin
          // Wrong-state wr_start is simply not looked at here.
          for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (count == CNT_W'(i)) begin
              left_reg[BIT_WIDTH*i +: BIT_WIDTH] <= col_reg[BIT_WIDTH*i +: BIT_WIDTH];
            end
          end
          if (count == CNT_LAST) begin
            count <= '0;
            state <= WR_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end

        WR_DONE: begin
          wr_done <= 1'b1;
          if (rd_start || pend) begin
            rd_x_reg <= rd_start ? rd_x : pend_x;
            rd_y_reg <= rd_start ? rd_y : pend_y;
            pend     <= 1'b0;
            state    <= RD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RD: begin
          // Line-buffer read is issued in the RAM process below.
          state <= RD_OUT;
        end

        RD_OUT: begin
          top      <= rd_in_range ? ram_q : '0;
          left     <= left_reg;
`ifdef NBR_DEFAULT_EN
          if (rd_y_reg == '0) begin
            top <= {BLOCK_SIZE{DEF_TOP}};
          end
          if (rd_x_reg == '0) begin
            left <= {BLOCK_SIZE{DEF_LEFT}};
          end
`endif
          rd_valid <= 1'b1;
          state    <= IDLE;
          busy     <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Line buffer: one bottom row per block column, registered read.
  // Contents are undefined until a column is written, so no reset here.
  // ---------------------------------------------------------------------
  logic [EDGE_W-1:0] linebuf [MAX_MB_W];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      linebuf[wr_x_reg[ADDR_W-1:0]] <= row_reg;
    end
    if (state == RD && rd_in_range) begin
      ram_q <= linebuf[rd_x_reg[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_pred_nbr_buf.sv
// ---------------------------------------------------------------------------
// tb_pred_nbr_buf
//
// Directed bench for pred_nbr_buf. A behavioural model tracks what each
// picture column's bottom row and the most recent right column should be
// (computed from the block pixel formula), and schedules for every clock
// cycle whether wr_done / rd_valid / busy must be high and what top/left
// must carry. One monitor compares the DUT against that schedule on every
// falling edge; a few literal expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_pred_nbr_buf;

  localparam int BW  = 8;
  localparam int BS  = 16;
  localparam int BN  = 10;
  localparam int MW  = 64;
  localparam int EW  = BW * BS;
  localparam int BLK = BW * BS * BS;
  localparam int NC  = 2048;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_start = 1'b0;
  logic           rd_start = 1'b0;
  logic [BN-1:0]  wr_x = '0;
  logic [BN-1:0]  rd_x = '0;
  logic [BN-1:0]  rd_y = '0;
  logic [BLK-1:0] recon = '0;
  logic           wr_done;
  logic           rd_valid;
  logic           busy;
  logic [EW-1:0]  top;
  logic [EW-1:0]  left;

  always #5 clk = ~clk;

  pred_nbr_buf #(
    .BIT_WIDTH (BW),
    .BLOCK_SIZE(BS),
    .BLOCK_NUM (BN),
    .MAX_MB_W  (MW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_start(wr_start),
    .wr_x    (wr_x),
    .recon   (recon),
    .wr_done (wr_done),
    .rd_start(rd_start),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .top     (top),
    .left    (left),
    .rd_valid(rd_valid),
    .busy    (busy)
  );

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle expectation schedule
  bit            exp_wd   [NC];
  bit            exp_rv   [NC];
  bit            exp_busy [NC];
  logic [EW-1:0] exp_top  [NC];
  logic [EW-1:0] exp_left [NC];

  // Model of stored picture edges
  logic [EW-1:0] line_m [MW];
  logic [EW-1:0] left_m;

  bit            mon_on = 1'b0;
  int            n_wd = 0;
  int            n_rv = 0;
  int            last_wd_cyc = -1;
  int            last_rv_cyc = -1;
  logic [EW-1:0] last_top = '0;
  logic [EW-1:0] last_left = '0;

  // ---------------- pixel formula and edge model ----------------
  function automatic logic [7:0] pix(int r, int c, int seed);
    return 8'((r * 16 + c + seed * 53) % 256);
  endfunction

  function automatic logic [BLK-1:0] make_block(int seed);
    logic [BLK-1:0] b;
    b = '0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        b[BW*(r*BS+c) +: BW] = pix(r, c, seed);
    return b;
  endfunction

  function automatic logic [EW-1:0] bottom_row(int seed);
    logic [EW-1:0] v;
    v = '0;
    for (int i = 0; i < BS; i++) v[BW*i +: BW] = pix(BS - 1, i, seed);
    return v;
  endfunction

  function automatic logic [EW-1:0] right_col(int seed);
    logic [EW-1:0] v;
    v = '0;
    for (int i = 0; i < BS; i++) v[BW*i +: BW] = pix(i, BS - 1, seed);
    return v;
  endfunction

  task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A write accepted at edge k: edges land in the model immediately,
  // wr_done shows after edge k+17, busy after edges k..k+16.
  task automatic sched_write(int k, int x, int seed);
    left_m = right_col(seed);
    if (x < MW) line_m[x] = bottom_row(seed);
    exp_wd[k + BS + 1] = 1'b1;
    for (int j = k; j <= k + BS; j++) exp_busy[j] = 1'b1;
  endtask

  // A read launched at edge s: busy after s and s+1, rd_valid after s+2.
  task automatic sched_read(int s, int x, int y);
    logic [EW-1:0] t;
    logic [EW-1:0] l;
    t = (x < MW) ? line_m[x] : '0;
    l = left_m;
`ifdef NBR_DEFAULT_EN
    if (y == 0) t = {16{8'h7F}};
    if (x == 0) l = {16{8'h81}};
`endif
    exp_rv[s + 2]   = 1'b1;
    exp_top[s + 2]  = t;
    exp_left[s + 2] = l;
    exp_busy[s]     = 1'b1;
    exp_busy[s + 1] = 1'b1;
  endtask

  // ---------------- monitor: compares every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && cyc < NC) begin
        check($sformatf("wr_done@%0d", cyc), EW'(wr_done), EW'(exp_wd[cyc]));
        check($sformatf("rd_valid@%0d", cyc), EW'(rd_valid), EW'(exp_rv[cyc]));
        check($sformatf("busy@%0d", cyc), EW'(busy), EW'(exp_busy[cyc]));
        if (exp_rv[cyc]) begin
          check($sformatf("top@%0d", cyc), top, exp_top[cyc]);
          check($sformatf("left@%0d", cyc), left, exp_left[cyc]);
        end
        if (wr_done) begin
          n_wd++;
          last_wd_cyc = cyc;
        end
        if (rd_valid) begin
          n_rv++;
          last_rv_cyc = cyc;
          last_top    = top;
          last_left   = left;
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic drive_write(int x, int seed, output int k);
    step();
    k        = cyc + 1;
    wr_start = 1'b1;
    wr_x     = BN'(x);
    recon    = make_block(seed);
    sched_write(k, x, seed);
    step();
    wr_start = 1'b0;
  endtask

  task automatic drive_read(int x, int y, output int k);
    step();
    k        = cyc + 1;
    rd_start = 1'b1;
    rd_x     = BN'(x);
    rd_y     = BN'(y);
    sched_read(k, x, y);
    step();
    rd_start = 1'b0;
  endtask

  // Pulse rd_start so it is sampled at edge e (no scheduling).
  task automatic pulse_rd_at(int e, int x, int y);
    while (cyc < e - 1) step();
    rd_start = 1'b1;
    rd_x     = BN'(x);
    rd_y     = BN'(y);
    step();
    rd_start = 1'b0;
  endtask

  // Pulse wr_start so it is sampled at edge e (must be ignored by the DUT).
  task automatic pulse_wr_at(int e, int x, int seed);
    while (cyc < e - 1) step();
    wr_start = 1'b1;
    wr_x     = BN'(x);
    recon    = make_block(seed);
    step();
    wr_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int k2;
    int wd0;
    int rv0;
    logic [EW-1:0] lit_row;
    logic [EW-1:0] lit_col;

    for (int j = 0; j < NC; j++) begin
      exp_wd[j]   = 1'b0;
      exp_rv[j]   = 1'b0;
      exp_busy[j] = 1'b0;
      exp_top[j]  = '0;
      exp_left[j] = '0;
    end
    left_m = '0;

    // Hand-computed edges of the r*16+c block
    for (int i = 0; i < BS; i++) begin
      lit_row[BW*i +: BW] = 8'(240 + i);
      lit_col[BW*i +: BW] = 8'(16 * i + 15);
    end

    // Reset state
    #1 rst = 1'b1;
    idle(3);
    check("reset_busy", EW'(busy), '0);
    check("reset_wr_done", EW'(wr_done), '0);
    check("reset_rd_valid", EW'(rd_valid), '0);
    check("reset_top", top, '0);
    check("reset_left", left, '0);
    rst = 1'b0;
    step();
    mon_on = 1'b1;

    // Column 0 preloaded for the final boundary read
    drive_write(0, 9, k);
    idle(20);

    // Basic write then read, x=3, pixel(r,c) = r*16+c
    drive_write(3, 0, k);
    idle(20);
    check("t1_wr_done_latency", EW'(last_wd_cyc - k), EW'(17));
    drive_read(3, 1, k2);
    idle(4);
    check("t1_rd_valid_latency", EW'(last_rv_cyc - k2), EW'(2));
    check("t1_top_literal", last_top, lit_row);
    check("t1_left_literal", last_left, lit_col);

    // Write and read in the same cycle, x=5
    wd0 = n_wd;
    rv0 = n_rv;
    step();
    k        = cyc + 1;
    wr_start = 1'b1;
    wr_x     = BN'(5);
    recon    = make_block(2);
    rd_start = 1'b1;
    rd_x     = BN'(5);
    rd_y     = BN'(1);
    sched_write(k, 5, 2);
    sched_read(k + BS + 1, 5, 1);
    step();
    wr_start = 1'b0;
    rd_start = 1'b0;
    idle(25);
    check("t2_one_wr_done", EW'(n_wd - wd0), EW'(1));
    check("t2_one_rd_valid", EW'(n_rv - rv0), EW'(1));
    check("t2_rd_after_wr", EW'(last_rv_cyc - last_wd_cyc), EW'(2));
    check("t2_top_new_row", last_top, bottom_row(2));

    // Two reads during WR_COL (last wins) plus an ignored write, x=2
    rv0 = n_rv;
    drive_write(2, 3, k);
    pulse_rd_at(k + 3, 1, 1);
    pulse_wr_at(k + 5, 11, 7);
    pulse_rd_at(k + 8, 2, 1);
    sched_read(k + BS + 1, 2, 1);
    idle(25);
    check("t3_one_rd_valid", EW'(n_rv - rv0), EW'(1));
    check("t3_top_last_wins", last_top, bottom_row(3));
    check("t3_left_not_overwritten", last_left, right_col(3));

    // Out-of-range column x=64
    drive_write(64, 5, k);
    idle(20);
    drive_read(64, 1, k2);
    idle(4);
    check("t4_top_zero", last_top, '0);
    check("t4_left_updated", last_left, right_col(5));
    drive_read(3, 2, k2);
    idle(4);
    check("t4_col3_unchanged", last_top, lit_row);

    // Reset in the middle of WR_COL at count 7, x=7
    drive_write(7, 4, k);
    while (cyc < k + 7) step();
    rst = 1'b1;
    for (int j = cyc + 1; j < NC; j++) begin
      exp_wd[j]   = 1'b0;
      exp_rv[j]   = 1'b0;
      exp_busy[j] = 1'b0;
    end
    left_m = '0;
    step();
    check("t5_busy_after_rst", EW'(busy), '0);
    step();
    rst = 1'b0;
    idle(20);
    drive_read(7, 1, k2);
    idle(4);
    check("t5_left_cleared", last_left, '0);
    check("t5_rd_valid_latency", EW'(last_rv_cyc - k2), EW'(2));

    // Boundary read x=0,y=0 after a write elsewhere
    drive_write(9, 6, k);
    idle(20);
    drive_read(0, 0, k2);
    idle(4);
`ifdef NBR_DEFAULT_EN
    check("t6_top_default", last_top, {16{8'h7F}});
    check("t6_left_default", last_left, {16{8'h81}});
`else
    check("t6_top_stored", last_top, bottom_row(9));
    check("t6_left_stored", last_left, right_col(6));
`endif

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
